// File: rtl/aes_decrypt_arbiter.sv
// Round-robin arbiter/sequencer sharing one AES decrypt core between two requesters,
// with a blind first WAIT cycle and a watchdog that turns a hung core into an error response.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a request; winner's ready asserted combinationally
// S_LAUNCH | one-cycle decipher_new_en pulse to the core
// S_WAIT   | counting cycles until core ready (first cycle blind) or timeout
// S_RESP   | tagged response held until the consumer accepts it
module aes_decrypt_arbiter #(
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_req0_valid,
   output logic         o_req0_ready,
   input  logic [127:0] i_req0_cipher_text,
   input  logic [127:0] i_req0_round_key_10,
   input  logic         i_req1_valid,
   output logic         o_req1_ready,
   input  logic [127:0] i_req1_cipher_text,
   input  logic [127:0] i_req1_round_key_10,
   output logic [127:0] o_core_cipher_text,
   output logic [127:0] o_core_round_key_10,
   output logic         o_core_decipher_new_en,
   input  logic         i_core_decipher_ready,
   input  logic [127:0] i_core_plain_text,
   output logic         o_rsp_valid,
   input  logic         i_rsp_ready,
   output logic         o_rsp_id,
   output logic [127:0] o_rsp_plain_text,
   output logic         o_rsp_error,
   output logic         o_busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]   r_state;
   logic         r_last_grant;
   logic         r_grant_id;
   logic [127:0] r_cipher;
   logic [127:0] r_key;
   logic [127:0] r_rsp_pt;
   logic         r_rsp_err;
   logic [7:0]   r_wait_cnt;

   logic w_idle;
   logic w_any_valid;
   logic w_winner;
   logic w_grant;
   logic w_core_done;
   logic w_timeout;

   assign w_idle      = (r_state == S_IDLE) && !i_reset;
   assign w_any_valid = i_req0_valid || i_req1_valid;
   // On a tie the requester not served last wins; otherwise the lone valid one.
   assign w_winner    = (i_req0_valid && i_req1_valid) ? ~r_last_grant : i_req1_valid;
   assign w_grant     = w_idle && w_any_valid;

   assign o_req0_ready = w_grant && !w_winner;
   assign o_req1_ready = w_grant &&  w_winner;

   // wait_cnt==0 is the blind cycle covering the core's stale ready level.
   assign w_core_done = (r_wait_cnt != 8'd0) && i_core_decipher_ready;
   assign w_timeout   = (r_wait_cnt == LP_WAIT_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_grant_id   <= 1'b0;
         r_cipher     <= '0;
         r_key        <= '0;
         r_rsp_pt     <= '0;
         r_rsp_err    <= 1'b0;
         r_wait_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_cipher     <= w_winner ? i_req1_cipher_text  : i_req0_cipher_text;
                  r_key        <= w_winner ? i_req1_round_key_10 : i_req0_round_key_10;
                  r_grant_id   <= w_winner;
                  r_last_grant <= w_winner;
                  r_state      <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_wait_cnt <= '0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wait_cnt != 8'hFF) begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
               if (w_core_done) begin
                  r_rsp_pt  <= i_core_plain_text;
                  r_rsp_err <= 1'b0;
                  r_state   <= S_RESP;
               end else if (w_timeout) begin
                  r_rsp_pt  <= '0;
                  r_rsp_err <= 1'b1;
                  r_state   <= S_RESP;
               end
            end
            S_RESP: begin
               if (i_rsp_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Request registers only change on a grant, so the core sees a held value outside LAUNCH/WAIT.
   assign o_core_cipher_text     = r_cipher;
   assign o_core_round_key_10    = r_key;
   assign o_core_decipher_new_en = (r_state == S_LAUNCH);

   assign o_rsp_valid      = (r_state == S_RESP);
   assign o_rsp_id         = r_grant_id;
   assign o_rsp_plain_text = r_rsp_pt;
   assign o_rsp_error      = r_rsp_err;
   assign o_busy           = (r_state != S_IDLE);

endmodule
